// File: rtl/router_slice_pkg.sv
// rtl/router_slice_pkg.sv - shared types and constants for the router slice arbiters
package router_slice_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after start, wrapping
module rr_pick
  import router_slice_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic found;
  int   j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/router_idata_arbiter.sv
// rtl/router_idata_arbiter.sv - round-robin, packet-locked arbiter feeding the shared IDATA register
module router_idata_arbiter
  import router_slice_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [ID_W-1:0]           out_src,
  input  logic                      out_ready
);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [ID_W-1:0]     out_src_q, out_src_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     next_ptr;
  logic                load_ok;
  logic                xfer;
  logic                xfer_last;
  logic [DATA_W-1:0]   xfer_data;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_pick (
    .req_i   (req_valid),
    .start_i (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // Register can take a new flit whenever it is empty or draining this cycle.
  assign load_ok   = !out_valid_q | out_ready;
  assign req_ready = load_ok ? grant : '0;
  assign xfer      = |(req_valid & req_ready);
  assign xfer_last = req_last[grant_idx];
  assign xfer_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];
  assign next_ptr  = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (state_q == LOCKED) begin
      grant_idx = owner_q;
      if (req_valid[owner_q]) grant[owner_q] = 1'b1;
    end else begin
      grant     = pick_grant;
      grant_idx = pick_idx;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (xfer) begin
      if (xfer_last) begin
        state_d  = IDLE;
        rr_ptr_d = next_ptr;
      end else begin
        state_d = LOCKED;
        owner_d = grant_idx;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (load_ok) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = xfer_data;
        out_last_d = xfer_last;
        out_src_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_router_idata_arbiter.sv
// tb/tb_router_idata_arbiter.sv - scoreboard bench with a behavioural arbitration model
module tb_router_idata_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic           out_valid, out_last, out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;

  logic [1:0]     req_valid2, req_last2, req_ready2;
  logic [2*W-1:0] req_data2;
  logic           out_valid2, out_last2, out_ready2;
  logic [W-1:0]   out_data2;
  logic [0:0]     out_src2;

  always #5 clk = ~clk;

  router_idata_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready)
  );

  router_idata_arbiter #(.NUM_REQ(2), .DATA_W(W)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_last(req_last2), .req_data(req_data2), .req_ready(req_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_last(out_last2), .out_src(out_src2),
    .out_ready(out_ready2)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic [1:0]   src;
  } item_t;

  item_t sb_q[$];
  int    src_log[$];
  int    checks   = 0;
  int    failures = 0;

  bit    m_valid;
  bit    m_locked;
  int    m_owner;
  int    m_rr;

  always @(negedge clk) begin
    item_t e;
    if (reset && out_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got src=%0d data=%h with no flit expected", out_src, out_data);
      end else begin
        e = sb_q[0];
        if ({out_data, out_last, out_src} !== {e.data, e.last, e.src}) begin
          failures++;
          $display("FAIL sb_flit: got data=%h last=%0d src=%0d expected data=%h last=%0d src=%0d",
                   out_data, out_last, out_src, e.data, e.last, e.src);
        end
        if (out_ready) begin
          void'(sb_q.pop_front());
          src_log.push_back(int'(e.src));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int n, input int e0, input int e1,
                         input int e2, input int e3, input int e4, input int e5,
                         input int e6, input int e7);
    int e[8];
    e = '{e0, e1, e2, e3, e4, e5, e6, e7};
    chk({name, "_len"}, 64'(src_log.size()), 64'(n));
    for (int i = 0; i < n && i < src_log.size(); i++)
      chk({name, "_src"}, 64'(src_log[i]), 64'(e[i]));
    src_log.delete();
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l,
                     input logic [N*W-1:0] d, input logic rdy);
    int           g;
    int           j;
    bit           load_ok;
    logic [N-1:0] er;
    req_valid = v;
    req_last  = l;
    req_data  = d;
    out_ready = rdy;
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    load_ok = !m_valid || rdy;
    g = -1;
    if (m_locked) begin
      if (v[m_owner]) g = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (g < 0 && v[j]) g = j;
      end
    end
    er = (load_ok && g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    if (load_ok) begin
      if (g >= 0) begin
        sb_q.push_back('{data: d[g*W +: W], last: l[g], src: 2'(g)});
        m_valid = 1'b1;
        if (l[g]) begin
          m_locked = 1'b0;
          m_rr     = (g + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_owner  = g;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc('0, '0, rnd_data(), 1'b1);
  endtask

  initial begin
    logic [N*W-1:0] d;
    reset      = 1'b0;
    req_valid  = '0;
    req_last   = '0;
    req_data   = '0;
    out_ready  = 1'b1;
    req_valid2 = '0;
    req_last2  = '0;
    req_data2  = '0;
    out_ready2 = 1'b1;
    m_valid    = 1'b0;
    m_locked   = 1'b0;
    m_owner    = 0;
    m_rr       = 0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    req_valid2 = 2'b10;
    req_last2  = 2'b11;
    req_data2  = {32'hC0FFEE01, 32'h0BADF00D};
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      chk("n2_valid", 64'(out_valid2), 64'd1);
      chk("n2_src", 64'(out_src2), 64'd1);
      chk("n2_data", 64'(out_data2), 64'hC0FFEE01);
      chk("n2_ready", 64'(req_ready2), 64'b10);
      idle(1);
    end

    src_log.delete();
    repeat (8) cyc(4'b1111, 4'b1111, rnd_data(), 1'b1);
    idle(2);
    chk_log("fair", 8, 0, 1, 2, 3, 0, 1, 2, 3);

    cyc(4'b0010, 4'b0000, rnd_data(), 1'b1);
    cyc(4'b0111, 4'b0000, rnd_data(), 1'b1);
    cyc(4'b0111, 4'b0010, rnd_data(), 1'b1);
    cyc(4'b0101, 4'b1111, rnd_data(), 1'b1);
    cyc(4'b0101, 4'b1111, rnd_data(), 1'b1);
    idle(2);
    chk_log("pkt", 5, 1, 1, 1, 2, 0, 0, 0, 0);

    d = rnd_data();
    d[2*W +: W] = 32'hDEADBEEF;
    cyc(4'b0100, 4'b0100, d, 1'b1);
    repeat (3) begin
      chk("stall_data", 64'(out_data), 64'hDEADBEEF);
      chk("stall_src", 64'(out_src), 64'd2);
      cyc(4'b1111, 4'b1111, rnd_data(), 1'b0);
    end
    cyc(4'b0001, 4'b1111, rnd_data(), 1'b1);
    idle(2);
    chk_log("stall", 2, 2, 0, 0, 0, 0, 0, 0, 0);

    cyc(4'b1000, 4'b0000, rnd_data(), 1'b1);
    cyc(4'b0001, 4'b0000, rnd_data(), 1'b1);
    cyc(4'b0001, 4'b0000, rnd_data(), 1'b1);
    cyc(4'b1001, 4'b1000, rnd_data(), 1'b1);
    cyc(4'b0001, 4'b0001, rnd_data(), 1'b1);
    idle(2);
    chk_log("bubble", 3, 3, 3, 0, 0, 0, 0, 0, 0);

    repeat (400)
      cyc(4'($urandom), 4'($urandom), rnd_data(), $urandom_range(0, 3) != 0);
    idle(3);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);

    cyc(4'b0001, 4'b0000, rnd_data(), 1'b1);
    req_valid = '0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_src", 64'(out_src), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    sb_q.delete();
    src_log.delete();
    m_valid  = 1'b0;
    m_locked = 1'b0;
    m_rr     = 0;
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(4'b0010, 4'b0010, rnd_data(), 1'b1);
    idle(2);
    chk_log("post_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
